// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares a single-port, synchronous-read data memory between the CPU
// load/store port (port 0) and a debug/DMA port (port 1) with round-robin priority.
//
// Ports:
//   clk, reset            clock; synchronous active-high reset
//   cpu_req_i/we_i/addr_i/wdata_i   CPU request (held until done)
//   cpu_rdata_o, cpu_rvalid_o       CPU load data and its one-cycle valid pulse
//   cpu_stall_o                     CPU must hold PC and register writes
//   dbg_req_i/we_i/addr_i/wdata_i   debug request (held until done)
//   dbg_gnt_o                       debug access issued this cycle
//   dbg_rdata_o, dbg_rvalid_o       debug read data and its one-cycle valid pulse
//   mem_addr_o/we_o/wdata_o         word address, write enable, write data to memory
//   mem_rdata_i                     memory read data, one cycle after the address
module dmem_arbiter #(
    parameter int unsigned DBITS     = 32,
    parameter int unsigned ADDR_BITS = 13,
    parameter int unsigned MEM_AW    = ADDR_BITS - 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req_i,
    input  logic              cpu_we_i,
    input  logic [DBITS-1:0]  cpu_addr_i,
    input  logic [DBITS-1:0]  cpu_wdata_i,
    output logic [DBITS-1:0]  cpu_rdata_o,
    output logic              cpu_rvalid_o,
    output logic              cpu_stall_o,
    input  logic              dbg_req_i,
    input  logic              dbg_we_i,
    input  logic [DBITS-1:0]  dbg_addr_i,
    input  logic [DBITS-1:0]  dbg_wdata_i,
    output logic              dbg_gnt_o,
    output logic [DBITS-1:0]  dbg_rdata_o,
    output logic              dbg_rvalid_o,
    output logic [MEM_AW-1:0] mem_addr_o,
    output logic              mem_we_o,
    output logic [DBITS-1:0]  mem_wdata_o,
    input  logic [DBITS-1:0]  mem_rdata_i
);

    typedef enum logic [1:0] {StIdle, StRdCpu, StRdDbg} state_e;

    state_e            state_q, state_d;
    logic              last_dbg_q, last_dbg_d;  // 1: debug won the most recent grant
    logic [DBITS-1:0]  cpu_rdata_q, cpu_rdata_d;
    logic [DBITS-1:0]  dbg_rdata_q, dbg_rdata_d;
    logic              cpu_rvalid_q, cpu_rvalid_d;
    logic              dbg_rvalid_q, dbg_rvalid_d;
    logic [MEM_AW-1:0] mem_addr_q, mem_addr_d;

    logic              can_grant;
    logic              cpu_win;
    logic              dbg_win;
    logic [MEM_AW-1:0] cpu_word;
    logic [MEM_AW-1:0] dbg_word;

    // Byte-offset and out-of-range address bits are intentionally dropped.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{cpu_addr_i[DBITS-1:ADDR_BITS], cpu_addr_i[1:0],
                                dbg_addr_i[DBITS-1:ADDR_BITS], dbg_addr_i[1:0]};

    assign cpu_word = cpu_addr_i[ADDR_BITS-1:2];
    assign dbg_word = dbg_addr_i[ADDR_BITS-1:2];

    // No grant in the cycle a read result is returned, so the finishing requester
    // has a cycle to drop its request before it could be re-granted.
    always_comb begin
        can_grant = (state_q == StIdle) && !reset && !cpu_rvalid_q && !dbg_rvalid_q;
        cpu_win   = can_grant && cpu_req_i && (!dbg_req_i || last_dbg_q);
        dbg_win   = can_grant && dbg_req_i && !cpu_win;
    end

    always_comb begin
        mem_addr_o  = mem_addr_q;
        mem_wdata_o = cpu_wdata_i;
        if (state_q == StIdle) begin
            mem_addr_o = dbg_win ? dbg_word : cpu_word;
        end
        if (dbg_win || (state_q == StRdDbg)) begin
            mem_wdata_o = dbg_wdata_i;
        end
        mem_we_o     = (cpu_win && cpu_we_i) || (dbg_win && dbg_we_i);
        dbg_gnt_o    = dbg_win;
        cpu_stall_o  = !reset && cpu_req_i && !((cpu_win && cpu_we_i) || cpu_rvalid_q);
        cpu_rdata_o  = cpu_rdata_q;
        cpu_rvalid_o = cpu_rvalid_q;
        dbg_rdata_o  = dbg_rdata_q;
        dbg_rvalid_o = dbg_rvalid_q;
    end

    always_comb begin
        state_d      = state_q;
        last_dbg_d   = last_dbg_q;
        cpu_rdata_d  = cpu_rdata_q;
        dbg_rdata_d  = dbg_rdata_q;
        cpu_rvalid_d = 1'b0;
        dbg_rvalid_d = 1'b0;
        mem_addr_d   = mem_addr_q;
        case (state_q)
            StIdle: begin
                mem_addr_d = mem_addr_o;
                if (cpu_win) begin
                    last_dbg_d = 1'b0;
                    if (!cpu_we_i) state_d = StRdCpu;
                end else if (dbg_win) begin
                    last_dbg_d = 1'b1;
                    if (!dbg_we_i) state_d = StRdDbg;
                end
            end
            StRdCpu: begin
                cpu_rdata_d  = mem_rdata_i;
                cpu_rvalid_d = 1'b1;
                state_d      = StIdle;
            end
            StRdDbg: begin
                dbg_rdata_d  = mem_rdata_i;
                dbg_rvalid_d = 1'b1;
                state_d      = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            last_dbg_q   <= 1'b1;
            cpu_rdata_q  <= '0;
            dbg_rdata_q  <= '0;
            cpu_rvalid_q <= 1'b0;
            dbg_rvalid_q <= 1'b0;
            mem_addr_q   <= '0;
        end else begin
            state_q      <= state_d;
            last_dbg_q   <= last_dbg_d;
            cpu_rdata_q  <= cpu_rdata_d;
            dbg_rdata_q  <= dbg_rdata_d;
            cpu_rvalid_q <= cpu_rvalid_d;
            dbg_rvalid_q <= dbg_rvalid_d;
            mem_addr_q   <= mem_addr_d;
        end
    end

endmodule
